// File: rtl/sobel_edge_if.sv
// sobel_edge_if: pixel stream into the Sobel block, processed pixel stream out, plus per-pixel mode controls.
// Revision: 1.0
`default_nettype none

interface sobel_edge_if;
  logic        pix_valid;
  logic [7:0]  in_R;
  logic [7:0]  in_G;
  logic [7:0]  in_B;
  logic [12:0] in_col;
  logic [12:0] in_row;
  logic        edge_en;
  logic        binarize;
  logic [7:0]  thresh_in;
  logic [7:0]  out_R;
  logic [7:0]  out_G;
  logic [7:0]  out_B;
  logic [12:0] out_col;
  logic [12:0] out_row;
  logic        out_valid;

  modport master (
    output pix_valid, in_R, in_G, in_B, in_col, in_row, edge_en, binarize, thresh_in,
    input  out_R, out_G, out_B, out_col, out_row, out_valid
  );

  modport slave (
    input  pix_valid, in_R, in_G, in_B, in_col, in_row, edge_en, binarize, thresh_in,
    output out_R, out_G, out_B, out_col, out_row, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/sobel_edge.sv
// sobel_edge: 3x3 Sobel edge detector on luma with two line buffers, optional binarize, RGB bypass.
// Revision: 1.0
`default_nettype none

module sobel_edge #(
  parameter int         H_LIMIT    = 640,
  parameter logic [7:0] THRESH_DEF = 8'd64
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  sobel_edge_if.slave vid
);
  localparam int AW = (H_LIMIT > 1) ? $clog2(H_LIMIT) : 1;

  typedef struct packed {
    logic        valid;
    logic [12:0] col;
    logic [12:0] row;
    logic [23:0] rgb;
    logic        edge_en;
    logic        binarize;
    logic [7:0]  thr;
    logic        kill;
  } meta_t;

  logic [7:0]         lb0_q [H_LIMIT];
  logic [7:0]         lb1_q [H_LIMIT];
  logic [AW-1:0]      addr;
  logic               accept;
  logic [9:0]         gray_sum;
  logic [7:0]         gray;
  logic [1:0]         line_cnt_q;
  meta_t              s0_d, s0_q, s1_q, s2_q;
  logic               s0_acc_q;
  logic [7:0]         s0_top_q, s0_mid_q, s0_gray_q;
  logic [7:0]         win_q [3][3];
  logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
  logic [10:0]        ax, ay;
  logic [11:0]        mag;
  logic [7:0]         sat, edge_px;
  logic [23:0]        rgb_d, out_rgb_q;
  logic [12:0]        out_col_q, out_row_q;
  logic               out_valid_q;

  assign accept   = vid.pix_valid && (vid.in_col < 13'(H_LIMIT));
  assign addr     = vid.in_col[AW-1:0];
  assign gray_sum = {2'b00, vid.in_R} + {1'b0, vid.in_G, 1'b0} + {2'b00, vid.in_B};
  assign gray     = gray_sum[9:2];

  // Line buffers are deliberately not reset; the line counter masks stale contents.
  always_ff @(posedge CLOCK_50) begin
    if (accept) begin
      lb0_q[addr] <= gray;
      lb1_q[addr] <= lb0_q[addr];
    end
  end

  always_comb begin
    s0_d.valid    = vid.pix_valid;
    s0_d.col      = vid.in_col;
    s0_d.row      = vid.in_row;
    s0_d.rgb      = {vid.in_R, vid.in_G, vid.in_B};
    s0_d.edge_en  = vid.edge_en;
    s0_d.binarize = vid.binarize;
    s0_d.thr      = (vid.thresh_in == 8'd0) ? THRESH_DEF : vid.thresh_in;
    s0_d.kill     = (vid.in_col < 13'd2) || (vid.in_row < 13'd2) || (line_cnt_q != 2'd2);
  end

  // Input capture: pixel metadata plus the column about to enter the window.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s0_q       <= '0;
      s0_acc_q   <= 1'b0;
      s0_top_q   <= '0;
      s0_mid_q   <= '0;
      s0_gray_q  <= '0;
      line_cnt_q <= '0;
    end else begin
      s0_q      <= s0_d;
      s0_acc_q  <= accept;
      s0_top_q  <= lb1_q[addr];
      s0_mid_q  <= lb0_q[addr];
      s0_gray_q <= gray;
      if (accept && (vid.in_col == 13'(H_LIMIT - 1)) && (line_cnt_q != 2'd2))
        line_cnt_q <= line_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      s1_q <= '0;
    end else begin
      s1_q <= s0_q;
      if (s0_acc_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= s0_top_q;
        win_q[1][2] <= s0_mid_q;
        win_q[2][2] <= s0_gray_q;
      end
    end
  end

  function automatic logic signed [10:0] tap3(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c);
    return signed'({3'b000, a}) + signed'({2'b00, b, 1'b0}) + signed'({3'b000, c});
  endfunction

  assign gx_d = tap3(win_q[0][2], win_q[1][2], win_q[2][2]) - tap3(win_q[0][0], win_q[1][0], win_q[2][0]);
  assign gy_d = tap3(win_q[2][0], win_q[2][1], win_q[2][2]) - tap3(win_q[0][0], win_q[0][1], win_q[0][2]);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      gx_q <= '0;
      gy_q <= '0;
      s2_q <= '0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
      s2_q <= s1_q;
    end
  end

  assign ax      = gx_q[10] ? unsigned'(-gx_q) : unsigned'(gx_q);
  assign ay      = gy_q[10] ? unsigned'(-gy_q) : unsigned'(gy_q);
  assign mag     = {1'b0, ax} + {1'b0, ay};
  assign sat     = (mag > 12'd255) ? 8'hFF : mag[7:0];
  assign edge_px = s2_q.kill ? 8'h00 :
                   s2_q.binarize ? ((sat >= s2_q.thr) ? 8'hFF : 8'h00) : sat;
  assign rgb_d   = s2_q.edge_en ? {3{edge_px}} : s2_q.rgb;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      out_rgb_q   <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_rgb_q   <= rgb_d;
      out_col_q   <= s2_q.col;
      out_row_q   <= s2_q.row;
      out_valid_q <= s2_q.valid;
    end
  end

  assign vid.out_R     = out_rgb_q[23:16];
  assign vid.out_G     = out_rgb_q[15:8];
  assign vid.out_B     = out_rgb_q[7:0];
  assign vid.out_col   = out_col_q;
  assign vid.out_row   = out_row_q;
  assign vid.out_valid = out_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge: randomized and directed frames checked against an image-domain Sobel reference.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_sobel_edge;
  localparam int H = 640;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_edge_if vid();

  sobel_edge #(.H_LIMIT(H), .THRESH_DEF(8'd64)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .vid      (vid)
  );

  typedef struct {
    logic [23:0] rgb;
    int          col;
    int          row;
    int          stamp;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         edges  = 0;
  int         img[3][H];
  int         lines  = 0;
  logic       cfg_edge = 1'b1;
  logic       cfg_bin  = 1'b0;
  logic [7:0] cfg_thr  = 8'd0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: Sobel evaluated directly on the image rows fed so far, centred at (row-1, col-1).
  function automatic logic [23:0] model(input int row, input int col, input logic [23:0] rgb);
    int p[3][3];
    int gx, gy, mag, thr, v;
    if (!cfg_edge) return rgb;
    if (col < 2 || row < 2 || lines < 2) return 24'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[(row - 2 + i) % 3][col - 2 + j];
    gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
    thr = (cfg_thr == 8'd0) ? 64 : int'(cfg_thr);
    v   = cfg_bin ? ((mag >= thr) ? 255 : 0) : mag;
    return {3{v[7:0]}};
  endfunction

  task automatic send(input logic v, input int row, input int col, input logic [23:0] rgb);
    exp_t e;
    vid.pix_valid = v;
    vid.in_R      = rgb[23:16];
    vid.in_G      = rgb[15:8];
    vid.in_B      = rgb[7:0];
    vid.in_col    = 13'(col);
    vid.in_row    = 13'(row);
    vid.edge_en   = cfg_edge;
    vid.binarize  = cfg_bin;
    vid.thresh_in = cfg_thr;
    if (v) begin
      img[row % 3][col] = (int'(rgb[23:16]) + 2*int'(rgb[15:8]) + int'(rgb[7:0])) / 4;
      e.rgb   = model(row, col, rgb);
      e.col   = col;
      e.row   = row;
      e.stamp = edges + 4;
      sb.push_back(e);
      if (col == H - 1 && lines < 2) lines++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pat(input int mode, input int col);
    case (mode)
      0:       return {3{8'd100}};
      1:       return (col >= 320) ? {3{8'd255}} : 24'd0;
      2:       return (col >= 320) ? {3{8'd10}} : 24'd0;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic run_cols(input int mode, input int row, input int c0, input int c1, input bit toggle);
    for (int c = c0; c <= c1; c++) begin
      if (mode == 3 && cfg_edge && (c % 80) == 0) begin
        cfg_bin = 1'($urandom_range(0, 1));
        cfg_thr = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      send(1'b1, row, c, pat(mode, c));
      if (toggle) send(1'b0, $urandom_range(0, 8000), $urandom_range(0, 8000), 24'($urandom));
    end
  endtask

  task automatic run_rows(input int mode, input int r0, input int n, input bit toggle);
    for (int r = r0; r < r0 + n; r++) run_cols(mode, r, 0, H - 1, toggle);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 0, 0, 24'd0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    vid.pix_valid = 1'b0;
    #1;
    chk("reset_clear_now", {vid.out_valid, vid.out_R, vid.out_G, vid.out_B, vid.out_col, vid.out_row}, 64'd0);
    sb.delete();
    lines = 0;
    @(posedge clk);
    #1;
    chk("reset_clear_held", {vid.out_valid, vid.out_R, vid.out_G, vid.out_B, vid.out_col, vid.out_row}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (vid.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", vid.out_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          chk("pixel_rgb", {vid.out_R, vid.out_G, vid.out_B}, mon_e.rgb);
          chk("pixel_pos", {vid.out_col, vid.out_row}, {13'(mon_e.col), 13'(mon_e.row)});
          chk("latency", edges, mon_e.stamp);
        end
      end else if (sb.size() != 0 && sb[0].stamp <= edges) begin
        chk("missing_valid", vid.out_valid, 1'b1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vid.pix_valid = 1'b0;
    vid.in_R = '0; vid.in_G = '0; vid.in_B = '0;
    vid.in_col = '0; vid.in_row = '0;
    vid.edge_en = 1'b1; vid.binarize = 1'b0; vid.thresh_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {vid.out_valid, vid.out_R, vid.out_G, vid.out_B, vid.out_col, vid.out_row}, 64'd0);
    rst_n = 1'b1;

    // flat field, magnitude output
    cfg_edge = 1'b1; cfg_bin = 1'b0; cfg_thr = 8'd0;
    run_rows(0, 0, 4, 1'b0);
    // vertical step, magnitude then binarized, then low step below default threshold
    run_rows(1, 0, 5, 1'b0);
    cfg_bin = 1'b1;
    run_rows(1, 0, 4, 1'b0);
    run_rows(2, 0, 3, 1'b0);
    // random image with binarize/threshold changing mid-line
    run_rows(3, 0, 4, 1'b0);
    // passthrough
    cfg_edge = 1'b0;
    run_rows(3, 0, 3, 1'b0);
    // reset mid-frame on the step image
    cfg_edge = 1'b1; cfg_bin = 1'b0; cfg_thr = 8'd0;
    idle(5);
    do_reset();
    run_rows(1, 98, 2, 1'b0);
    run_cols(1, 100, 0, 299, 1'b0);
    do_reset();
    run_cols(1, 100, 300, H - 1, 1'b0);
    run_rows(1, 101, 3, 1'b0);
    // pix_valid toggling every cycle
    run_rows(1, 0, 4, 1'b1);

    idle(8);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/sobel_edge.md
SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 SHALL have parameter H_LIMIT, default 640, meaning active pixels per line (line-buffer depth).
REQ-002 SHALL have parameter THRESH_DEF, default 8'd64, meaning the binarize threshold used when thresh_in is 0.
REQ-003 SHALL have port CLOCK_50 input 1: single clock; all state on rising edge.
REQ-004 SHALL have port RESET_N input 1: asynchronous, active-low reset.
REQ-005 SHALL have port pix_valid input 1: the in_* pixel is accepted this cycle.
REQ-006 SHALL have ports in_R, in_G, in_B input 8 each: camera RGB.
REQ-007 SHALL have ports in_col, in_row input 13 each: coordinates of the input pixel.
REQ-008 SHALL have port edge_en input 1: 1 outputs the edge image, 0 passes RGB through.
REQ-009 SHALL have port binarize input 1: 1 outputs a thresholded 0/255 result, 0 outputs the saturated magnitude.
REQ-010 SHALL have port thresh_in input 8: binarize threshold; 0 selects THRESH_DEF.
REQ-011 SHALL have ports out_R, out_G, out_B output 8 each: raw_VGA_* feed to the cursor overlay.
REQ-012 SHALL have ports out_col, out_row output 13 each: in_col/in_row delayed to match.
REQ-013 SHALL have port out_valid output 1: pix_valid delayed.

Function
REQ-014 SHALL compute gray = (in_R + 2*in_G + in_B) >> 2 at 10-bit width, truncated to 8 bits.
REQ-015 SHALL keep two H_LIMIT x 8 line buffers; on pix_valid, write gray to LB0[in_col] and old LB0[in_col] to LB1[in_col].
REQ-016 SHALL shift the 3x3 window one column on each pix_valid, new column = {LB1[in_col], LB0[in_col], gray} (top..bottom); the window SHALL hold when pix_valid is 0.
REQ-017 SHALL centre the window at (in_col-1, in_row-1); the output image is offset by one pixel right and down.
REQ-018 SHALL compute Gx = (p02+2p12+p22)-(p00+2p10+p20) and Gy = (p20+2p21+p22)-(p00+2p01+p02) as 11-bit signed values.
REQ-019 SHALL compute mag = |Gx|+|Gy| at 12 bits, saturated to 255.
REQ-020 SHALL drive out_R = out_G = out_B = (mag >= thr ? 255 : 0) when binarize is 1, where thr is thresh_in or THRESH_DEF.
REQ-021 SHALL drive out_R = out_G = out_B = mag when binarize is 0.
REQ-022 SHALL force the edge result to 0 when the delayed in_col < 2, in_row < 2, or line_cnt < 2.
REQ-023 SHALL keep a 2-bit counter line_cnt that increments, saturating at 2, on an accepted pixel with in_col == H_LIMIT-1.
REQ-024 SHALL use a fixed 3-stage pipeline: stage 1 window/gray, stage 2 Gx/Gy, stage 3 magnitude/select; the pipeline advances every clock regardless of pix_valid.
REQ-025 SHALL present out_valid, out_col, out_row and out_RGB three rising edges after the edge on which the input was sampled.
REQ-026 SHALL, when edge_en is 0, drive out_RGB = in_RGB delayed through the same 3 stages (same latency).
REQ-027 SHALL sample edge_en, binarize and thresh_in at stage 1 and carry them down the pipeline, so a mid-stream change affects only pixels accepted afterwards.
REQ-028 SHALL ignore (not buffer) in_col >= H_LIMIT.

Reset
REQ-029 SHALL, while RESET_N is 0, clear immediately all pipeline registers, window registers, line_cnt, out_valid and out_* (all 0).
REQ-030 SHALL not reset line-buffer contents; stale data is masked by REQ-022 until two full lines are written after reset.
REQ-031 SHALL accept a pixel on the first rising edge after RESET_N deasserts.

Verification
REQ-032 SHALL pass this scenario: flat field R=G=B=100, edge_en=1, binarize=0, full frame -> every out_RGB = 0; out_valid matches pix_valid delayed exactly 3 cycles.
REQ-033 SHALL pass this scenario: vertical step R=G=B=0 for col<320 and 255 for col>=320, rows>=2 -> out = 255 at out_col 320 and 321, 0 elsewhere (Gx = 1020 saturated).
REQ-034 SHALL pass this scenario: same step, binarize=1, thresh_in=0 -> 255 at cols 320/321, 0 elsewhere; repeat with a step height of 10 (0->10, mag 40 < 64) -> all outputs 0.
REQ-035 SHALL pass this scenario: edge_en=0 with random RGB -> out_RGB, out_col and out_row equal the inputs from 3 cycles earlier; rows 0-1 are not zeroed.
REQ-036 SHALL pass this scenario: RESET_N pulsed low mid-frame at row 100 with the step image -> out_* = 0 immediately; edge outputs stay 0 until line_cnt == 2, then match REQ-033.
REQ-037 SHALL pass this scenario: pix_valid toggling 1/0 every cycle with the step image -> output values identical to the continuous case, with gaps where pix_valid was 0.
